// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   First-word-fall-through byte buffer that sits directly in front of the UART
//   transmitter. A producer pushes words with a valid/ready handshake, and the
//   UART pops the head word with tx_vld/tx_rdy.
//
//   Ports
//     clk, reset    clock; synchronous active-high reset
//     flush         synchronous clear of the contents; takes priority over push/pop
//     in_vld/in_rdy/in_data   producer side (push = in_vld && in_rdy)
//     tx_vld/tx_rdy/tx_data   UART side (pop = tx_vld && tx_rdy); tx_data = head word
//     count         number of words stored
//     empty, full, almost_full (count >= AFULL_LVL)
//     underrun      sticky; set if a pop happens while the count register says
//                   empty (a pointer/count disagreement). Cleared by reset or flush.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [DATA_BITS-1:0]         in_data,
    output logic                         tx_vld,
    input  logic                         tx_rdy,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         underrun
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_WL = IDX_W + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [PTR_WL-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WL-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              underrun_q, underrun_d;

    logic ptr_empty;
    logic ptr_full;
    logic push;
    logic pop;

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    assign ptr_empty = (wr_ptr_q == rd_ptr_q);
    assign ptr_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                       (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

    assign in_rdy = !ptr_full && !flush;
    assign tx_vld = !ptr_empty;

    assign push = in_vld && in_rdy;
    assign pop  = tx_vld && tx_rdy && !flush;

    assign tx_data     = mem[rd_ptr_q[IDX_W-1:0]];
    assign count       = count_q;
    assign empty       = ptr_empty;
    assign full        = ptr_full;
    assign almost_full = (count_q >= CNT_W'(AFULL_LVL));
    assign underrun    = underrun_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        underrun_d = underrun_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            underrun_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_WL'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_WL'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            // Pointers claim data while the count says empty: internal fault.
            if (pop && (count_q == '0)) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage is deliberately not reset; tx_data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= in_data;
        end
    end

    a_count_max : assert property (@(posedge clk) disable iff (reset)
        count_q <= CNT_W'(DEPTH));
    a_not_full_empty : assert property (@(posedge clk) disable iff (reset)
        !(ptr_full && ptr_empty));
    a_count_ptrs : assert property (@(posedge clk) disable iff (reset)
        count_q == CNT_W'(wr_ptr_q - rd_ptr_q));
    a_tx_stable : assert property (@(posedge clk) disable iff (reset)
        (tx_vld && !tx_rdy && !flush) |=> $stable(tx_data));

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_LVL = 12;
    localparam int FRAME_CYC = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_vld;
    logic                 in_rdy;
    logic [DATA_BITS-1:0] in_data;
    logic                 tx_vld;
    logic                 tx_rdy;
    logic [DATA_BITS-1:0] tx_data;
    logic [4:0]           count;
    logic                 empty;
    logic                 full;
    logic                 almost_full;
    logic                 underrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of stored words.
    logic [DATA_BITS-1:0] model_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_BITS(DATA_BITS),
        .DEPTH    (DEPTH),
        .AFULL_LVL(AFULL_LVL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .tx_vld     (tx_vld),
        .tx_rdy     (tx_rdy),
        .tx_data    (tx_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .underrun   (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check combinational outputs against the model,
    // clock, update the model from the handshake rules, check registered outputs.
    task automatic cycle(input logic rst, input logic v, input logic [DATA_BITS-1:0] d,
                         input logic r, input logic f,
                         output logic pushed, output logic popped,
                         output logic [DATA_BITS-1:0] pop_data);
        int n;
        reset = rst; in_vld = v; in_data = d; tx_rdy = r; flush = f;
        #1;
        n = model_q.size();
        check("in_rdy", {31'd0, in_rdy}, {31'd0, (n < DEPTH) && !f});
        check("tx_vld", {31'd0, tx_vld}, {31'd0, n > 0});
        if (n > 0) check("tx_data", {24'd0, tx_data}, {24'd0, model_q[0]});
        pushed   = !rst && !f && v && (n < DEPTH);
        popped   = !rst && !f && r && (n > 0);
        pop_data = (n > 0) ? model_q[0] : '0;
        @(posedge clk);
        #1;
        if (rst || f) begin
            model_q.delete();
        end else begin
            if (popped) void'(model_q.pop_front());
            if (pushed) model_q.push_back(d);
        end
        n = model_q.size();
        check("count", {27'd0, count}, n);
        check("empty", {31'd0, empty}, {31'd0, n == 0});
        check("full", {31'd0, full}, {31'd0, n == DEPTH});
        check("almost_full", {31'd0, almost_full}, {31'd0, n >= AFULL_LVL});
        check("underrun", {31'd0, underrun}, 32'd0);
    endtask

    task automatic step(input logic rst, input logic v, input logic [DATA_BITS-1:0] d,
                        input logic r, input logic f);
        logic pu, po;
        logic [DATA_BITS-1:0] pd;
        cycle(rst, v, d, r, f, pu, po, pd);
    endtask

    initial begin
        logic pu, po;
        logic [DATA_BITS-1:0] pd;
        logic [DATA_BITS-1:0] msg [3];
        logic [DATA_BITS-1:0] rx [$];
        int busy;
        int sent;
        int guard;

        reset = 1'b1; flush = 1'b0; in_vld = 1'b0; in_data = '0; tx_rdy = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
        check("reset_tx_vld", {31'd0, tx_vld}, 32'd0);

        // 1: single push, visible next cycle
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        check("t1_tx_data", {24'd0, tx_data}, 32'hA5);
        check("t1_count", {27'd0, count}, 32'd1);

        // 2: fill to DEPTH, 17th word held off
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i + 1 == AFULL_LVL - 1) check("t2_afull_below", {31'd0, almost_full}, 32'd0);
            if (i + 1 == AFULL_LVL) check("t2_afull_at", {31'd0, almost_full}, 32'd1);
        end
        check("t2_full", {31'd0, full}, 32'd1);
        step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        check("t2_held_count", {27'd0, count}, DEPTH);

        // 3: pop one from full, then 0x10 accepted next cycle, then drain
        cycle(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, pu, po, pd);
        check("t3_no_push_on_full", {31'd0, pu}, 32'd0);
        check("t3_pop_data", {24'd0, pd}, 32'h00);
        check("t3_in_rdy_after", {31'd0, in_rdy}, 32'd1);
        step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, pu, po, pd);
            check("t3_drain_order", {24'd0, pd}, i);
        end
        check("t3_empty", {31'd0, empty}, 32'd1);

        // 4: count held at 5 with simultaneous push/pop across several wraps
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0);
        check("t4_count", {27'd0, count}, 32'd5);

        // 5: flush at count 9 with in_vld high
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        check("t5_count9", {27'd0, count}, 32'd9);
        cycle(1'b0, 1'b1, 8'h77, 1'b0, 1'b1, pu, po, pd);
        check("t5_flush_tx_vld", {31'd0, tx_vld}, 32'd0);

        // Random traffic with occasional flush and mid-operation reset
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 60),
                 8'($urandom),
                 ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 30 : 70)),
                 ($urandom_range(0, 149) == 0));
        end

        // UART-like consumer: takes one word when idle, then busy for a frame
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
        busy = 0; sent = 0; guard = 0;
        while ((rx.size() < 3) && (guard < 200)) begin
            cycle(1'b0, sent < 3, (sent < 3) ? msg[sent] : 8'h00, busy == 0, 1'b0, pu, po, pd);
            if (pu) sent++;
            if (po) begin
                rx.push_back(pd);
                busy = FRAME_CYC;
            end else if (busy > 0) begin
                busy--;
            end
            guard++;
        end
        check("uart_timeout", guard < 200, 32'd1);
        check("uart_frames", rx.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx.size()) check("uart_byte", {24'd0, rx[i]}, {24'd0, msg[i]});
        end
        check("uart_empty", {31'd0, empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
